// File: rtl/nrm_vc_statistics_collector_pkg.sv
// Shared definitions for the NRM per-VC statistics collector: flit type
// codes that mark the start of a packet and the width of the missed field.
package nrm_vc_statistics_collector_pkg;

  localparam int MISSED_WIDTH = 8;

  localparam logic [1:0] FLIT_TYPE_HEADER = 2'b01;
  localparam logic [1:0] FLIT_TYPE_SINGLE = 2'b11;

  localparam logic [MISSED_WIDTH-1:0] MISSED_MAX = '1;

endpackage

// File: rtl/nrm_vc_link_counter.sv
// Per-link event counters: one saturating counter and one sticky overflow
// bit per virtual channel, qualified by count_mode and cleared on tick.
// The next-state values are exported so the record can include the event
// that coincides with the tick.
module nrm_vc_link_counter
  import nrm_vc_statistics_collector_pkg::*;
#(
  parameter int V  = 3,
  parameter int CW = 8,
  parameter int TW = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [TW-1:0]   flit_type,
  input  logic [V-1:0]    valid,
  input  logic [V-1:0]    ready,
  input  logic            count_mode,
  input  logic            tick,
  output logic [V*CW-1:0] counts_next,
  output logic [V-1:0]    ovf_next
);

  logic [V*CW-1:0] counts;
  logic [V-1:0]    ovf;
  logic            packet_start;

  assign packet_start = (flit_type == TW'(FLIT_TYPE_HEADER)) ||
                        (flit_type == TW'(FLIT_TYPE_SINGLE));

  // Saturating increment per VC; a hit on a full counter marks overflow.
  always_comb begin
    // NOTE: outputs take their hold value first so no path leaves them unassigned (no latch).
    counts_next = counts;
    ovf_next    = ovf;
    for (int v = 0; v < V; v++) begin
      if (valid[v] && ready[v] && (!count_mode || packet_start)) begin
        if (&counts[v*CW +: CW]) begin
          ovf_next[v] = 1'b1;
        end else begin
          counts_next[v*CW +: CW] = counts[v*CW +: CW] + CW'(1);
        end
      end
    end
  end

  // Counter state; a tick starts a fresh interval.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst || tick) begin
      counts <= '0;
      ovf    <= '0;
    end else begin
      counts <= counts_next;
      ovf    <= ovf_next;
    end
  end

endmodule

// File: rtl/nrm_vc_statistics_collector.sv
// NRM per-link, per-VC statistics collector: interval timer, record
// register with valid/ready output, and a count of records lost to
// back-pressure.
module nrm_vc_statistics_collector
  import nrm_vc_statistics_collector_pkg::*;
#(
  parameter int MONITORED_LINK_COUNT  = 5,
  parameter int NOC_FLIT_DATA_WIDTH   = 32,
  parameter int NOC_FLIT_TYPE_WIDTH   = 2,
  parameter int NOC_VCHANNELS         = 3,
  parameter int COUNTER_WIDTH         = 8,
  parameter int SAMPLE_INTERVAL_WIDTH = 16,
  parameter int TIMESTAMP_WIDTH       = 32,
  localparam int NOC_FLIT_WIDTH = NOC_FLIT_DATA_WIDTH + NOC_FLIT_TYPE_WIDTH,
  localparam int LV             = MONITORED_LINK_COUNT * NOC_VCHANNELS,
  localparam int COUNTS_WIDTH   = LV * COUNTER_WIDTH,
  localparam int RECORD_WIDTH   = TIMESTAMP_WIDTH + MISSED_WIDTH + LV + COUNTS_WIDTH
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic [MONITORED_LINK_COUNT*NOC_FLIT_WIDTH-1:0] noc32_router_link_in_flit,
  input  logic [LV-1:0]                                noc32_router_link_in_valid,
  input  logic [LV-1:0]                                noc32_router_link_in_ready,
  input  logic [TIMESTAMP_WIDTH-1:0]                   timestamp,
  input  logic [SAMPLE_INTERVAL_WIDTH-1:0]             sample_interval,
  input  logic                                         count_mode,
  output logic [RECORD_WIDTH-1:0]                      trace_out,
  output logic                                         trace_out_valid,
  input  logic                                         trace_out_ready
);

  localparam int V  = NOC_VCHANNELS;
  localparam int FW = NOC_FLIT_WIDTH;
  localparam int TW = NOC_FLIT_TYPE_WIDTH;

  logic [SAMPLE_INTERVAL_WIDTH-1:0] timer;
  logic [MISSED_WIDTH-1:0]          missed;
  logic [COUNTS_WIDTH-1:0]          counts_next;
  logic [LV-1:0]                    ovf_next;
  logic                             tick;
  logic                             slot_free;
  logic                             unused_flit_payload;

  // Payload bits carry no statistics; only the type field is inspected.
  assign unused_flit_payload = ^noc32_router_link_in_flit;

  // >= (not ==) lets a shortened interval tick at once instead of wrapping.
  assign tick      = (sample_interval != '0) && (timer >= sample_interval);
  assign slot_free = !trace_out_valid || trace_out_ready;

  for (genvar i = 0; i < MONITORED_LINK_COUNT; i++) begin : g_link
    nrm_vc_link_counter #(
      .V  (V),
      .CW (COUNTER_WIDTH),
      .TW (TW)
    ) u_link_counter (
      .clk         (clk),
      .rst         (rst),
      .flit_type   (noc32_router_link_in_flit[i*FW + FW-1 -: TW]),
      .valid       (noc32_router_link_in_valid[i*V +: V]),
      .ready       (noc32_router_link_in_ready[i*V +: V]),
      .count_mode  (count_mode),
      .tick        (tick),
      .counts_next (counts_next[i*V*COUNTER_WIDTH +: V*COUNTER_WIDTH]),
      .ovf_next    (ovf_next[i*V +: V])
    );
  end

  // Interval timer: held at zero while sampling is disabled.
  always_ff @(posedge clk) begin
    if (rst || (sample_interval == '0) || tick) begin
      timer <= '0;
    end else begin
      timer <= timer + 1'b1;
    end
  end

  // Record capture, loss accounting and output handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the wide record register is reset too, because a reset must present an all-zero record.
      trace_out       <= '0;
      trace_out_valid <= 1'b0;
      missed          <= '0;
    end else if (tick && slot_free) begin
      trace_out       <= {timestamp, missed, ovf_next, counts_next};
      trace_out_valid <= 1'b1;
      missed          <= '0;
    end else begin
      if (tick && (missed != MISSED_MAX)) begin
        missed <= missed + 1'b1;
      end
      if (trace_out_valid && trace_out_ready) begin
        trace_out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_nrm_vc_statistics_collector.sv
// Scoreboard bench for nrm_vc_statistics_collector: a behavioural model
// queues expected records; a monitor compares whatever the DUT presents.
module tb_nrm_vc_statistics_collector;

  localparam int L = 2, V = 3, CW = 4, DW = 32, TW = 2, SW = 16, TSW = 32;
  localparam int FW = DW + TW, LV = L * V, RW = TSW + 8 + LV + LV * CW;
  localparam int CMAX = (1 << CW) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [L*FW-1:0]   flit = '0;
  logic [LV-1:0]     in_valid = '0;
  logic [LV-1:0]     in_ready = '0;
  logic [TSW-1:0]    timestamp = '0;
  logic [SW-1:0]     sample_interval = '0;
  logic              count_mode = 1'b0;
  logic [RW-1:0]     trace_out;
  logic              trace_out_valid;
  logic              trace_out_ready = 1'b0;

  always #5 clk = ~clk;

  nrm_vc_statistics_collector #(
    .MONITORED_LINK_COUNT  (L),
    .NOC_FLIT_DATA_WIDTH   (DW),
    .NOC_FLIT_TYPE_WIDTH   (TW),
    .NOC_VCHANNELS         (V),
    .COUNTER_WIDTH         (CW),
    .SAMPLE_INTERVAL_WIDTH (SW),
    .TIMESTAMP_WIDTH       (TSW)
  ) dut (
    .clk                        (clk),
    .rst                        (rst),
    .noc32_router_link_in_flit  (flit),
    .noc32_router_link_in_valid (in_valid),
    .noc32_router_link_in_ready (in_ready),
    .timestamp                  (timestamp),
    .sample_interval            (sample_interval),
    .count_mode                 (count_mode),
    .trace_out                  (trace_out),
    .trace_out_valid            (trace_out_valid),
    .trace_out_ready            (trace_out_ready)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int cnt_of(input logic [RW-1:0] r, input int idx);
    return int'(r[idx*CW +: CW]);
  endfunction

  function automatic int ovf_of(input logic [RW-1:0] r, input int idx);
    return int'(r[LV*CW + idx]);
  endfunction

  function automatic int missed_of(input logic [RW-1:0] r);
    return int'(r[LV*CW + LV +: 8]);
  endfunction

  // ---------------- reference model ----------------
  logic [RW-1:0] exp_q[$];
  int  m_cnt[LV];
  bit  m_ovf[LV];
  int  m_timer, m_missed;
  bit  m_pending;

  always @(posedge clk) begin
    bit xfer, m_tick;
    logic [1:0] ftype;
    logic [RW-1:0] rec;
    if (rst) begin
      for (int k = 0; k < LV; k++) begin m_cnt[k] = 0; m_ovf[k] = 0; end
      m_timer = 0; m_missed = 0; m_pending = 0;
      exp_q.delete();
    end else begin
      xfer = m_pending && trace_out_ready;
      for (int k = 0; k < LV; k++) begin
        ftype = flit[(k / V) * FW + FW - 1 -: 2];
        if (in_valid[k] && in_ready[k] && (!count_mode || ftype == 2'b01 || ftype == 2'b11)) begin
          if (m_cnt[k] == CMAX) m_ovf[k] = 1;
          else m_cnt[k] = m_cnt[k] + 1;
        end
      end
      m_tick = (sample_interval != 0) && (m_timer >= int'(sample_interval));
      if (m_tick) begin
        if (!m_pending || xfer) begin
          rec = '0;
          rec[RW-1 -: TSW] = timestamp;
          rec[LV*CW + LV +: 8] = 8'(m_missed);
          for (int k = 0; k < LV; k++) begin
            rec[LV*CW + k] = m_ovf[k];
            rec[k*CW +: CW] = CW'(m_cnt[k]);
          end
          exp_q.push_back(rec);
          m_pending = 1;
          m_missed = 0;
        end else begin
          m_missed = (m_missed < 255) ? m_missed + 1 : 255;
        end
        for (int k = 0; k < LV; k++) begin m_cnt[k] = 0; m_ovf[k] = 0; end
        m_timer = 0;
      end else begin
        if (xfer) m_pending = 0;
        m_timer = (sample_interval == 0) ? 0 : m_timer + 1;
      end
    end
  end

  // ---------------- monitor ----------------
  logic [RW-1:0] last_rec = '0;
  int rec_seen = 0;

  always @(negedge clk) begin
    if (!rst) begin
      check("valid", trace_out_valid, exp_q.size() != 0);
      if (trace_out_valid && exp_q.size() != 0) begin
        check("record", trace_out, exp_q[0]);
        if (trace_out_ready) begin
          last_rec = trace_out;
          void'(exp_q.pop_front());
          rec_seen++;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [LV-1:0] v, input logic [LV-1:0] r,
                       input logic [1:0] t0, input logic [1:0] t1);
    in_valid  = v;
    in_ready  = r;
    flit      = {t1, 32'($urandom), t0, 32'($urandom)};
    timestamp = $urandom;
    step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = '0;
    in_ready = '0;
    step();
    step();
    check("reset_valid", trace_out_valid, 0);
    check("reset_data", trace_out, 0);
    rst = 1'b0;
  endtask

  logic [1:0] pkt_types[5] = '{2'b01, 2'b00, 2'b00, 2'b10, 2'b11};

  initial begin
    int seen;
    logic [LV-1:0] rv, rr;

    // Basic interval of 10 cycles.
    trace_out_ready = 1'b1;
    sample_interval = 16'd9;
    count_mode = 1'b0;
    do_reset();
    for (int k = 0; k < 10; k++) begin
      rv = '0;
      if (k < 4) rv[1] = 1'b1;
      if (k < 2) rv[5] = 1'b1;
      drive(rv, '1, 2'b00, 2'b00);
      if (k == 8) check("basic_not_yet", trace_out_valid, 0);
    end
    check("basic_valid", trace_out_valid, 1);
    check("basic_counts", trace_out[LV*CW-1:0], 24'h200040);
    check("basic_ovf", trace_out[LV*CW +: LV], 0);
    check("basic_missed", missed_of(trace_out), 0);

    // Saturation, then a clean interval.
    sample_interval = 16'd31;
    do_reset();
    for (int k = 0; k < 32; k++) drive((k < 20) ? 6'b000001 : 6'b0, '1, 2'b00, 2'b00);
    check("sat_count", cnt_of(trace_out, 0), 15);
    check("sat_ovf", ovf_of(trace_out, 0), 1);
    for (int k = 0; k < 32; k++) drive((k < 3) ? 6'b000001 : 6'b0, '1, 2'b00, 2'b00);
    check("post_sat_count", cnt_of(trace_out, 0), 3);
    check("post_sat_ovf", ovf_of(trace_out, 0), 0);

    // Packet versus flit counting.
    sample_interval = 16'd4;
    count_mode = 1'b1;
    do_reset();
    for (int k = 0; k < 5; k++) drive(6'b000001, '1, pkt_types[k], 2'b00);
    check("packet_mode", cnt_of(trace_out, 0), 2);
    count_mode = 1'b0;
    for (int k = 0; k < 5; k++) drive(6'b000001, '1, pkt_types[k], 2'b00);
    check("flit_mode", cnt_of(trace_out, 0), 5);

    // Back-pressure: two ticks lost while the first record is held.
    sample_interval = 16'd3;
    trace_out_ready = 1'b0;
    do_reset();
    for (int k = 0; k < 16; k++) begin
      if (k == 12) trace_out_ready = 1'b1;
      drive(6'b000001, '1, 2'b00, 2'b00);
      if (k == 3) check("bp_first_count", cnt_of(trace_out, 0), 4);
    end
    check("bp_first_missed", missed_of(last_rec), 0);
    check("bp_missed", missed_of(trace_out), 2);
    check("bp_count", cnt_of(trace_out, 0), 4);

    // Valid without ready never counts.
    sample_interval = 16'd4;
    do_reset();
    for (int k = 0; k < 5; k++) drive('1, '0, 2'b00, 2'b00);
    check("noready_valid", trace_out_valid, 1);
    check("noready_counts", trace_out[LV*CW-1:0], 0);

    // Enabling sampling from 0.
    sample_interval = 16'd0;
    do_reset();
    for (int k = 0; k < 6; k++) drive('0, '0, 2'b00, 2'b00);
    check("disabled", trace_out_valid, 0);
    sample_interval = 16'd4;
    for (int k = 0; k < 4; k++) drive('0, '0, 2'b00, 2'b00);
    check("enable_early", trace_out_valid, 0);
    drive('0, '0, 2'b00, 2'b00);
    check("enable_tick", trace_out_valid, 1);

    // Shrinking the interval below the timer ticks at once.
    sample_interval = 16'd20;
    do_reset();
    for (int k = 0; k < 10; k++) drive('0, '0, 2'b00, 2'b00);
    check("shrink_before", trace_out_valid, 0);
    sample_interval = 16'd2;
    trace_out_ready = 1'b0;
    drive('0, '0, 2'b00, 2'b00);
    check("shrink_tick", trace_out_valid, 1);

    // Reset while a record is pending discards it.
    rst = 1'b1;
    step();
    check("rst_valid", trace_out_valid, 0);
    check("rst_data", trace_out, 0);
    rst = 1'b0;
    trace_out_ready = 1'b1;
    sample_interval = 16'd0;
    seen = rec_seen;
    for (int k = 0; k < 10; k++) drive('0, '0, 2'b00, 2'b00);
    check("rst_no_stale", trace_out_valid, 0);
    check("rst_no_record", rec_seen, seen);

    // Randomised traffic against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) sample_interval = 16'($urandom_range(0, 7));
      if (c % 50 == 0) count_mode = 1'($urandom_range(0, 1));
      trace_out_ready = ($urandom_range(0, 3) != 0);
      rv = 6'($urandom);
      rr = '0;
      for (int i = 0; i < L; i++) begin
        int vc;
        vc = $urandom_range(0, V);
        if (vc < V) rr[i*V + vc] = 1'b1;
      end
      drive(rv, rr, 2'($urandom), 2'($urandom));
    end

    // Drain.
    trace_out_ready = 1'b1;
    sample_interval = 16'd0;
    for (int k = 0; k < 5; k++) drive('0, '0, 2'b00, 2'b00);
    check("drain_queue", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
